// File: rtl/xor_decipher_rx.sv
// -----------------------------------------------------------------------------
// xor_decipher_rx
//
// Receive side of the serial XOR cipher link. A WIDTH-bit key is shifted in
// serially (synchronous to clk), then ciphertext bits are captured on rising
// edges of the transmitter's slow bit clock. Every WIDTH bits the word is XORed
// with the key and presented on oData_out with a one-clk oValid pulse. After
// MSG_LEN words the block parks in DONE with oDone_flag held high.
//
// Ports:
//   clk          system clock, rising edge
//   iRst         asynchronous active-low reset
//   iEn          global enable; 0 freezes FSM, counters and output registers
//   iLoad_key    high while key bits are presented on iData_in (one per clk)
//   iLoad_msg    rising edge starts message reception (needs a loaded key)
//   iData_in     serial key bits / ciphertext bits, MSB first
//   iClk_slow    transmitter bit clock, asynchronous to clk
//   oData_out    last recovered plaintext word
//   oValid       one-clk pulse when oData_out updates
//   oKey_ready   key register holds a full WIDTH-bit key
//   oDone_flag   MSG_LEN words received
//   oDbg_state   current FSM state (0 IDLE, 1 LOAD_KEY, 2 RECV, 3 DONE)
//
// Handshake: there is no back-pressure. oValid is a single-cycle strobe that
// qualifies oData_out; the consumer must take the word in that cycle.
// WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module xor_decipher_rx #(
    parameter int WIDTH   = 8,
    parameter int MSG_LEN = 4
) (
    input  logic             clk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iLoad_key,
    input  logic             iLoad_msg,
    input  logic             iData_in,
    input  logic             iClk_slow,
    output logic [WIDTH-1:0] oData_out,
    output logic             oValid,
    output logic             oKey_ready,
    output logic             oDone_flag,
    output logic [1:0]       oDbg_state
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int WCNT_W = $clog2(MSG_LEN + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WIDTH);
    localparam logic [WCNT_W-1:0] WCNT_ZERO = '0;
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MSG_LEN - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LOAD_KEY = 2'd1;
    localparam logic [1:0] S_RECV     = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detectors. These run whenever out of
    // reset, independent of iEn, so the edge detector never sees a stale
    // history when the block is re-enabled.
    // ------------------------------------------------------------------
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic data_s1_q, data_s2_q;
    logic load_msg_prev_q;

    always_ff @(posedge clk or negedge iRst) begin
        if (!iRst) begin
            clk_s1_q        <= 1'b0;
            clk_s2_q        <= 1'b0;
            clk_prev_q      <= 1'b0;
            data_s1_q       <= 1'b0;
            data_s2_q       <= 1'b0;
            load_msg_prev_q <= 1'b0;
        end else begin
            clk_s1_q        <= iClk_slow;
            clk_s2_q        <= clk_s1_q;
            clk_prev_q      <= clk_s2_q;
            data_s1_q       <= iData_in;
            data_s2_q       <= data_s1_q;
            load_msg_prev_q <= iLoad_msg;
        end
    end

    logic slow_edge;
    logic load_msg_rise;

    // Data goes through the same two-flop depth as the clock, so the bit
    // sampled on a detected edge is the one that was stable at the slow edge.
    assign slow_edge     = clk_s2_q & ~clk_prev_q;
    assign load_msg_rise = iLoad_msg & ~load_msg_prev_q;

    // ------------------------------------------------------------------
    // Main state
    // ------------------------------------------------------------------
    logic [1:0]        state_q,     state_d;
    logic [WIDTH-1:0]  key_q,       key_d;
    logic [WIDTH-1:0]  shift_q,     shift_d;
    logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [WCNT_W-1:0] word_cnt_q,  word_cnt_d;
    logic [WIDTH-1:0]  data_out_q,  data_out_d;
    logic              valid_q,     valid_d;
    logic              key_ready_q, key_ready_d;
    logic              done_q,      done_d;

    logic go_load;
    logic go_recv;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        key_ready_d = key_ready_q;
        done_d      = done_q;
        go_load     = 1'b0;
        go_recv     = 1'b0;

        if (iEn) begin
            case (state_q)
                S_IDLE: begin
                    // Key load has priority over message start.
                    if (iLoad_key) begin
                        go_load = 1'b1;
                    end else if (load_msg_rise && key_ready_q) begin
                        go_recv = 1'b1;
                    end
                end

                S_LOAD_KEY: begin
                    if (iLoad_key) begin
                        // Keep shifting past WIDTH so the last WIDTH bits win;
                        // the counter only needs to know "at least WIDTH".
                        key_d = {key_q[WIDTH-2:0], iData_in};
                        if (bit_cnt_q != CNT_FULL) begin
                            bit_cnt_d = bit_cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d     = S_IDLE;
                        key_ready_d = (bit_cnt_q == CNT_FULL);
                        bit_cnt_d   = CNT_ZERO;
                    end
                end

                S_RECV: begin
                    if (iLoad_key) begin
                        // Abort: partial word is dropped, no strobe.
                        go_load = 1'b1;
                    end else if (bit_cnt_q == CNT_FULL) begin
                        // Word completed on the previous edge; publish it.
                        // The slow bit period spans many clk, so no edge
                        // coincides with this cycle.
                        data_out_d = shift_q ^ key_q;
                        valid_d    = 1'b1;
                        bit_cnt_d  = CNT_ZERO;
                        word_cnt_d = word_cnt_q + WCNT_ONE;
                        if (word_cnt_q == WCNT_LAST) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else if (slow_edge) begin
                        shift_d   = {shift_q[WIDTH-2:0], data_s2_q};
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end

                S_DONE: begin
                    if (iLoad_key) begin
                        go_load = 1'b1;
                    end else if (load_msg_rise) begin
                        go_recv = 1'b1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Entering LOAD_KEY: the key is cleared and the bit present in
            // this cycle is already the first key bit, so holding iLoad_key
            // for N clk always shifts exactly N bits.
            if (go_load) begin
                state_d     = S_LOAD_KEY;
                key_d       = {{(WIDTH-1){1'b0}}, iData_in};
                bit_cnt_d   = CNT_ONE;
                key_ready_d = 1'b0;
                done_d      = 1'b0;
            end

            if (go_recv) begin
                state_d    = S_RECV;
                shift_d    = '0;
                bit_cnt_d  = CNT_ZERO;
                word_cnt_d = WCNT_ZERO;
                done_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge iRst) begin
        if (!iRst) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= CNT_ZERO;
            word_cnt_q  <= WCNT_ZERO;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            key_ready_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            key_ready_q <= key_ready_d;
            done_q      <= done_d;
        end
    end

    assign oData_out  = data_out_q;
    assign oValid     = valid_q;
    assign oKey_ready = key_ready_q;
    assign oDone_flag = done_q;
    assign oDbg_state = state_q;

endmodule
